sync_fifo_flags: RTL and testbench
==================================

SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of wr_data and rd_data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3: pointer width; depth DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter AFULL_TH, default 6: almost_full asserts when count >= AFULL_TH; legal range 1..DEPTH.
REQ-004 SHALL have parameter AEMPTY_TH, default 1: almost_empty asserts when count <= AEMPTY_TH; legal range 0..DEPTH-1.
REQ-005 SHALL have parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 wr_en  input  1  write request.
REQ-009 wr_data  input  DATA_WIDTH  write data.
REQ-010 rd_en  input  1  read request (pop in FWFT mode).
REQ-011 rd_data  output  DATA_WIDTH  read data.
REQ-012 rd_valid  output  1  rd_data qualifier.
REQ-013 full / empty  output  1 each  count == DEPTH / count == 0.
REQ-014 almost_full / almost_empty  output  1 each  threshold flags per REQ-003/004.
REQ-015 fifo_cnt  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-016 overflow / underflow  output  1 each  one-cycle error pulses.

Function
REQ-017 Write SHALL be accepted iff wr_en && !full; the word is stored at wr_ptr and wr_ptr increments modulo DEPTH.
REQ-018 Read SHALL be accepted iff rd_en && !empty; rd_ptr increments modulo DEPTH.
REQ-019 fifo_cnt SHALL be +1 on accepted write only, -1 on accepted read only, unchanged when both or neither accepted.
REQ-020 Acceptance SHALL use the flags of the current cycle: wr_en while full is rejected even if a read is accepted in the same cycle; rd_en while empty is rejected even if a write is accepted in the same cycle.
REQ-021 full, empty, almost_full, almost_empty SHALL be decoded only from the registered fifo_cnt (no combinational path from wr_en/rd_en).
REQ-022 FWFT=0: on an accepted read, rd_data SHALL load mem[rd_ptr] at that edge and rd_valid SHALL be 1 for exactly the following cycle; otherwise rd_valid = 0 and rd_data holds its last value.
REQ-023 FWFT=1: rd_data SHALL equal mem[rd_ptr] and rd_valid SHALL equal !empty continuously; a word written into an empty FIFO appears one cycle after the write edge.
REQ-024 overflow SHALL be 1 for the cycle after an edge where wr_en && full; the word is dropped and no state changes.
REQ-025 underflow SHALL be 1 for the cycle after an edge where rd_en && empty; pointers and rd_data unchanged, rd_valid = 0.
REQ-026 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; data order SHALL be strict FIFO across wraps.
REQ-027 Storage memory SHALL not require reset; outputs SHALL never present uninitialised memory while rd_valid = 1.

Reset
REQ-028 rst_n low SHALL asynchronously force: wr_ptr = 0, rd_ptr = 0, fifo_cnt = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, rd_valid = 0, overflow = 0, underflow = 0, rd_data = 0 (FWFT=0).
REQ-029 Reset asserted mid-operation SHALL discard all stored words; the first write after deassertion SHALL be read back first.
REQ-030 Release of rst_n SHALL take effect at the next rising clk; wr_en/rd_en in that first cycle are processed normally.

Verification
REQ-031 Defaults, FWFT=0: write 0x11..0x88 over 8 cycles -> full=1, fifo_cnt=8, almost_full=1 from count 6; then 8 reads -> rd_data 0x11..0x88 each with rd_valid one cycle after rd_en, empty=1 at end.
REQ-032 Full FIFO, wr_en=1 with wr_data=0xAA -> overflow pulse 1 cycle, fifo_cnt stays 8, 0xAA never read back.
REQ-033 Empty FIFO, rd_en=1 -> underflow pulse 1 cycle, rd_valid=0, fifo_cnt=0; simultaneous wr_en=1 rd_en=1 while empty -> write accepted, fifo_cnt=1, underflow=1.
REQ-034 fifo_cnt=4, wr_en=rd_en=1 for 20 cycles with incrementing data -> fifo_cnt stays 4, pointers wrap, read order matches write order exactly.
REQ-035 FWFT=1: write 0x5A into empty FIFO -> next cycle rd_valid=1, rd_data=0x5A without rd_en; rd_en=1 -> empty=1 and rd_valid=0 the following cycle.
REQ-036 After 5 writes, pulse rst_n low between clock edges -> all outputs reach REQ-028 values immediately; write 0x33 then read -> 0x33 returned.

Source files
------------

// File: rtl/sync_fifo_flags_if.sv
// Bundle of the FIFO write/read request signals and status flags.
// The master drives requests; the slave (the FIFO) answers with data and flags.
interface sync_fifo_flags_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    // Handshake: a write is taken on a rising edge when wr_en=1 and full=0;
    // a read is taken when rd_en=1 and empty=0. rd_valid qualifies rd_data.
    // Requests against full/empty are dropped and flagged.
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   fifo_cnt;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               fifo_cnt, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               fifo_cnt, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy counter, threshold flags, error pulses and
// a choice between registered-read and first-word-fall-through output.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AFULL_TH   = 6,
    parameter int AEMPTY_TH  = 1,
    parameter int FWFT       = 0
) (
    input logic              clk,
    input logic              rst_n,
    sync_fifo_flags_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic full, empty, wr_acc, rd_acc;

    // Flags come only from the registered count, so requests never loop back.
    assign full   = (cnt_q == DEPTH_C);
    assign empty  = (cnt_q == '0);
    assign wr_acc = bus.wr_en && !full;
    assign rd_acc = bus.rd_en && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        overflow_d  = bus.wr_en && full;
        underflow_d = bus.rd_en && empty;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
            rd_data_d  = mem[rd_ptr_q];
            rd_valid_d = 1'b1;
        end
        case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is left unreset; pointers and count define which words are live.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.rd_data      = (FWFT != 0) ? mem[rd_ptr_q] : rd_data_q;
    assign bus.rd_valid     = (FWFT != 0) ? !empty : rd_valid_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (cnt_q >= AFULL_C);
    assign bus.almost_empty = (cnt_q <= AEMPTY_C);
    assign bus.fifo_cnt     = cnt_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Drives a registered-read and a FWFT instance with the same stimulus and
// checks both against a queue-based model of FIFO behaviour.
module tb_sync_fifo_flags;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF_TH = 6;
  localparam int AE_TH = 1;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_rd0;
  logic          exp_v0;
  logic          exp_ovf;
  logic          exp_udf;

  sync_fifo_flags_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 ();
  sync_fifo_flags_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();

  assign if0.wr_en   = wr_en;
  assign if0.wr_data = wr_data;
  assign if0.rd_en   = rd_en;
  assign if1.wr_en   = wr_en;
  assign if1.wr_data = wr_data;
  assign if1.rd_en   = rd_en;

  sync_fifo_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_TH(AF_TH),
                    .AEMPTY_TH(AE_TH), .FWFT(0)) u_dut_reg (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));

  sync_fifo_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_TH(AF_TH),
                    .AEMPTY_TH(AE_TH), .FWFT(1)) u_dut_fwft (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int n;
    n = exp_q.size();
    check_eq("cnt_reg",      32'(if0.fifo_cnt), n);
    check_eq("cnt_fwft",     32'(if1.fifo_cnt), n);
    check_eq("full",         32'(if0.full), 32'(n == DEPTH));
    check_eq("empty",        32'(if0.empty), 32'(n == 0));
    check_eq("almost_full",  32'(if0.almost_full), 32'(n >= AF_TH));
    check_eq("almost_empty", 32'(if0.almost_empty), 32'(n <= AE_TH));
    check_eq("overflow",     32'(if0.overflow), 32'(exp_ovf));
    check_eq("underflow",    32'(if0.underflow), 32'(exp_udf));
    check_eq("udf_fwft",     32'(if1.underflow), 32'(exp_udf));
    check_eq("rd_valid_reg", 32'(if0.rd_valid), 32'(exp_v0));
    check_eq("rd_data_reg",  32'(if0.rd_data), 32'(exp_rd0));
    check_eq("rd_valid_fwft", 32'(if1.rd_valid), 32'(n != 0));
    if (n != 0) check_eq("rd_data_fwft", 32'(if1.rd_data), 32'(exp_q[0]));
  endtask

  // One clock of stimulus; the model applies the FIFO rules using the
  // occupancy seen before the edge.
  task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re);
    int  n;
    logic full_m, empty_m;
    @(negedge clk);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    n       = exp_q.size();
    full_m  = (n == DEPTH);
    empty_m = (n == 0);
    exp_ovf = we && full_m;
    exp_udf = re && empty_m;
    exp_v0  = re && !empty_m;
    if (exp_v0) exp_rd0 = exp_q.pop_front();
    if (we && !full_m) exp_q.push_back(wd);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Asserts reset between clock edges and checks outputs before any edge.
  task automatic async_reset();
    #2;
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_rd0 = '0;
    exp_v0  = 1'b0;
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    exp_rd0 = '0;
    exp_v0  = 1'b0;
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // fill with 0x11..0x88, then drain
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i * 8'h11), 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);

    // overflow on full, 0xAA must never come out
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
    cycle(1'b1, 8'hAA, 1'b0);
    cycle(1'b1, 8'hAA, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);

    // underflow, then simultaneous write+read while empty
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h77, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // steady occupancy of 4 with concurrent traffic across pointer wraps
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h40 + i), 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);

    // first word falls through without a read request
    cycle(1'b1, 8'h5A, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // mid-operation asynchronous reset
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
    async_reset();
    cycle(1'b1, 8'h33, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);

    // randomized traffic, alternating fill-biased and drain-biased phases
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 60; i++) begin
        int wp;
        wp = (ph % 2 == 0) ? 75 : 25;
        cycle(1'($urandom_range(0, 99) < wp), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 99) >= wp));
      end
    end
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
